// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (I) and load/store (D) requesters.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on a tie; when undefined, D wins every tie.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic        IAck,
  output logic [31:0] IRData,
  input  logic        DReq,
  input  logic        DWrite,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWData,
  input  logic [1:0]  DBHW,
  output logic        DAck,
  output logic [31:0] DRData,
  output logic        Err,
  output logic        Busy,
  output logic        MemReq,
  output logic        MemWrite,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [1:0]  MemBHW,
  input  logic        MemAck,
  input  logic [31:0] MemRData
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [15:0] TimerLast = 16'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic        owner_d_q, owner_d_d;   // 1 = D owns the access, 0 = I
  logic        last_d_q, last_d_d;
  logic [15:0] timer_q, timer_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  mem_bhw_q, mem_bhw_d;
  logic        iack_q, iack_d;
  logic        dack_q, dack_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic [31:0] irdata_q, irdata_d;
  logic [31:0] drdata_q, drdata_d;
  logic        gnt_d;

  always_comb begin
    state_d     = state_q;
    owner_d_d   = owner_d_q;
    last_d_d    = last_d_q;
    timer_d     = timer_q;
    mem_req_d   = mem_req_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_bhw_d   = mem_bhw_q;
    irdata_d    = irdata_q;
    drdata_d    = drdata_q;
    iack_d      = 1'b0;
    dack_d      = 1'b0;
    err_d       = 1'b0;
    gnt_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (IReq || DReq) begin
          if (IReq && DReq) begin
`ifdef ARB_ROUND_ROBIN_EN
            gnt_d = ~last_d_q;
`else
            gnt_d = 1'b1;
`endif
          end else begin
            gnt_d = DReq;
          end
          // Fetches are always plain word reads regardless of the D-side fields.
          mem_addr_d  = gnt_d ? DAddr  : IAddr;
          mem_wdata_d = gnt_d ? DWData : 32'd0;
          mem_write_d = gnt_d & DWrite;
          mem_bhw_d   = gnt_d ? DBHW   : 2'd2;
          mem_req_d   = 1'b1;
          owner_d_d   = gnt_d;
          last_d_d    = gnt_d;
          timer_d     = 16'd0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (MemAck) begin
          mem_req_d = 1'b0;
          if (owner_d_q) begin
            dack_d   = 1'b1;
            drdata_d = mem_write_q ? 32'd0 : MemRData;
          end else begin
            iack_d   = 1'b1;
            irdata_d = MemRData;
          end
          state_d = RESP;
        end else if ((TIMEOUT_CYC != 0) && (timer_q == TimerLast)) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (owner_d_q) begin
            dack_d   = 1'b1;
            drdata_d = 32'd0;
          end else begin
            iack_d   = 1'b1;
            irdata_d = 32'd0;
          end
          state_d = RESP;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      owner_d_q   <= 1'b0;
      last_d_q    <= 1'b1;
      timer_q     <= 16'd0;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_bhw_q   <= 2'd2;
      iack_q      <= 1'b0;
      dack_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      irdata_q    <= 32'd0;
      drdata_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      owner_d_q   <= owner_d_d;
      last_d_q    <= last_d_d;
      timer_q     <= timer_d;
      mem_req_q   <= mem_req_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_bhw_q   <= mem_bhw_d;
      iack_q      <= iack_d;
      dack_q      <= dack_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      irdata_q    <= irdata_d;
      drdata_q    <= drdata_d;
    end
  end

  assign IAck     = iack_q;
  assign DAck     = dack_q;
  assign Err      = err_q;
  assign Busy     = busy_q;
  assign IRData   = irdata_q;
  assign DRData   = drdata_q;
  assign MemReq   = mem_req_q;
  assign MemWrite = mem_write_q;
  assign MemAddr  = mem_addr_q;
  assign MemWData = mem_wdata_q;
  assign MemBHW   = mem_bhw_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, multi-cycle sequences and random
// transactions checked against a transaction-level model of arbitration and memory contents.
module tb_mem_port_arbiter;

  localparam int TO = 8;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        IReq = 1'b0, DReq = 1'b0, DWrite = 1'b0;
  logic [31:0] IAddr = '0, DAddr = '0, DWData = '0;
  logic [1:0]  DBHW = 2'd2;
  logic        IAck, DAck, Err, Busy, MemReq, MemWrite;
  logic [31:0] IRData, DRData, MemAddr, MemWData;
  logic [1:0]  MemBHW;
  logic        MemAck = 1'b0;
  logic [31:0] MemRData = '0;

  mem_port_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .Clk(Clk), .Reset(Reset),
    .IReq(IReq), .IAddr(IAddr), .IAck(IAck), .IRData(IRData),
    .DReq(DReq), .DWrite(DWrite), .DAddr(DAddr), .DWData(DWData), .DBHW(DBHW),
    .DAck(DAck), .DRData(DRData), .Err(Err), .Busy(Busy),
    .MemReq(MemReq), .MemWrite(MemWrite), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemBHW(MemBHW), .MemAck(MemAck), .MemRData(MemRData)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] def_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Memory environment: acks after mem_lat wait cycles, or every cycle when ack_tie is set.
  logic [31:0] rmem [bit [31:0]];
  int mem_lat = 0;
  bit ack_tie = 1'b0;
  int wcnt = 0;

  always @(negedge Clk) begin
    if (MemReq) begin
      if (ack_tie || wcnt >= mem_lat) begin
        MemAck = 1'b1;
        if (MemWrite) begin
          rmem[MemAddr] = MemWData;
          MemRData = 32'hBAD0_0000 ^ MemAddr;
        end else begin
          MemRData = rmem.exists(MemAddr) ? rmem[MemAddr] : def_word(MemAddr);
        end
      end else begin
        MemAck = 1'b0;
      end
      wcnt++;
    end else begin
      wcnt = 0;
      MemAck = ack_tie;
      MemRData = 32'h1234_5678;
    end
  end

  // Reference model state: pending requests, last grant, expected memory image.
  logic [31:0] mmem [bit [31:0]];
  bit i_pend = 1'b0, d_pend = 1'b0, last_d = 1'b1;

  task automatic service(input int lat, input bit drop,
                         output logic [31:0] o_data, output bit o_err, output int o_lat);
    bit exp_d, exp_err, ew, done, seen, hold_ok;
    logic [31:0] ea, ewd, exp_data;
    logic [1:0] eb;
    int exp_n;
    done = 0; seen = 0; hold_ok = 1;
    o_data = '0; o_err = 0; o_lat = -1;
    if (i_pend && d_pend) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = !last_d;
`else
      exp_d = 1'b1;
`endif
    end else begin
      exp_d = d_pend;
    end
    last_d  = exp_d;
    ea      = exp_d ? DAddr : IAddr;
    ew      = exp_d & DWrite;
    eb      = exp_d ? DBHW : 2'd2;
    ewd     = exp_d ? DWData : 32'd0;
    exp_err = (lat > TO - 1);
    exp_n   = exp_err ? TO + 1 : lat + 2;
    if (exp_err || ew) exp_data = 32'd0;
    else exp_data = mmem.exists(ea) ? mmem[ea] : def_word(ea);
    if (!exp_err && ew) mmem[ea] = ewd;
    mem_lat = lat;
    for (int n = 1; n <= 40 && !done; n++) begin
      @(negedge Clk);
      if (MemReq) begin
        if (!seen) check("cmd", {MemAddr, MemWData, MemWrite, MemBHW}, {ea, ewd, ew, eb});
        else if ({MemAddr, MemWData, MemWrite, MemBHW} !== {ea, ewd, ew, eb}) hold_ok = 0;
        seen = 1;
      end
      if (n == 1 && drop) begin
        if (exp_d) begin DAddr = ~DAddr; DWData = ~DWData; DWrite = ~DWrite; end
        else IAddr = ~IAddr;
      end
      if (IAck || DAck) begin
        done = 1;
        o_data = exp_d ? DRData : IRData;
        o_err  = Err;
        o_lat  = n;
        check("ack_who", {IAck, DAck}, {!exp_d, exp_d});
        check("ack_err", Err, exp_err);
        check("ack_lat", n, exp_n);
        check("ack_data", o_data, exp_data);
        check("ack_memreq", MemReq, 1'b0);
        check("cmd_hold", hold_ok, 1'b1);
        if (drop) begin
          if (exp_d) DReq = 1'b0; else IReq = 1'b0;
        end
        i_pend = IReq;
        d_pend = DReq;
      end
    end
    if (!done) check("ack_never_seen", 1'b0, 1'b1);
    @(negedge Clk);
    check("idle_busy", {Busy, IAck, DAck, Err}, 4'b0000);
  endtask

  typedef struct {
    bit          is_d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  bhw;
    int          lat;
    logic [31:0] exp_data;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [31:0] od;
    bit oe;
    int ol;
    int lt;

    tbl[0] = '{0, 0, 32'h100, 32'h0,        2'd2, 3,  32'h8C01_0004, 0, 5};
    tbl[1] = '{1, 1, 32'h040, 32'hDEADBEEF, 2'd2, 1,  32'h0,         0, 3};
    tbl[2] = '{1, 0, 32'h040, 32'h0,        2'd2, 0,  32'hDEADBEEF,  0, 2};
    tbl[3] = '{1, 0, 32'h044, 32'h0,        2'd2, 20, 32'h0,         1, 9};
    tbl[4] = '{1, 0, 32'h040, 32'h0,        2'd2, 7,  32'hDEADBEEF,  0, 9};
    tbl[5] = '{1, 1, 32'h041, 32'h0000_00AB, 2'd0, 2, 32'h0,         0, 4};
    tbl[6] = '{0, 0, 32'h041, 32'h0,        2'd2, 0,  32'h0000_00AB, 0, 2};
    tbl[7] = '{1, 1, 32'h048, 32'h0000_0011, 2'd1, 8, 32'h0,         1, 9};
    tbl[8] = '{1, 0, 32'h048, 32'h0,        2'd2, 0,  32'h5A5A_0F47, 0, 2};

    rmem[32'h100] = 32'h8C01_0004;
    mmem[32'h100] = 32'h8C01_0004;

    // Reset values
    repeat (3) @(negedge Clk);
    check("rst_ctrl", {IAck, DAck, Err, Busy, MemReq, MemWrite}, 6'b0);
    check("rst_addr", MemAddr, 32'd0);
    check("rst_wdata", MemWData, 32'd0);
    check("rst_bhw", MemBHW, 2'd2);
    check("rst_rdata", {IRData, DRData}, 64'd0);
    Reset = 1'b1;
    @(negedge Clk);

    // Directed vectors
    foreach (tbl[i]) begin
      IReq = !tbl[i].is_d;
      DReq = tbl[i].is_d;
      if (tbl[i].is_d) begin
        DWrite = tbl[i].wr; DAddr = tbl[i].addr; DWData = tbl[i].wdata; DBHW = tbl[i].bhw;
        IAddr = $urandom;
      end else begin
        IAddr = tbl[i].addr;
        DWrite = 1'b1; DAddr = $urandom; DWData = $urandom; DBHW = 2'd0;
      end
      i_pend = IReq; d_pend = DReq;
      service(tbl[i].lat, 1'b1, od, oe, ol);
      check($sformatf("vec%0d_data", i), od, tbl[i].exp_data);
      check($sformatf("vec%0d_err", i), oe, tbl[i].exp_err);
      check($sformatf("vec%0d_lat", i), ol, tbl[i].exp_lat);
    end

    // Zero-wait memory, fetch request held continuously
    IReq = 1'b1; IAddr = 32'h300; DReq = 1'b0; ack_tie = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge Clk);
      check($sformatf("zw_ack%0d", k), {IAck, DAck}, {(k % 3) == 2, 1'b0});
      if (k == 14) IReq = 1'b0;
    end
    ack_tie = 1'b0;
    last_d = 1'b0;
    i_pend = 1'b0; d_pend = 1'b0;
    @(negedge Clk);
    check("zw_idle", Busy, 1'b0);

    // Reset in the middle of a hung access
    DReq = 1'b1; DWrite = 1'b0; DAddr = 32'h80; mem_lat = 100;
    repeat (3) @(negedge Clk);
    check("rb_busy", {MemReq, Busy}, 2'b11);
    Reset = 1'b0;
    #1;
    check("rb_now", {MemReq, Busy, DAck, IAck, Err}, 5'b0);
    check("rb_vals", {MemAddr, MemBHW}, {32'd0, 2'd2});
    repeat (2) @(negedge Clk);
    check("rb_noack", {DAck, IAck}, 2'b0);
    DReq = 1'b0;
    Reset = 1'b1;
    last_d = 1'b1;
    @(negedge Clk);
    DReq = 1'b1; DWrite = 1'b0; DAddr = 32'h040; d_pend = 1'b1; i_pend = 1'b0;
    service(1, 1'b1, od, oe, ol);
    check("rb_fresh", {od, oe}, {32'hDEADBEEF, 1'b0});

    // Both requests held through four accesses
    IReq = 1'b1; IAddr = 32'h100; DReq = 1'b1; DWrite = 1'b0; DAddr = 32'h048;
    i_pend = 1'b1; d_pend = 1'b1;
    for (int k = 0; k < 4; k++) service(1, 1'b0, od, oe, ol);
    IReq = 1'b0; DReq = 1'b0; i_pend = 1'b0; d_pend = 1'b0;
    @(negedge Clk);

    // Random traffic
    for (int r = 0; r < 150; r++) begin
      if (!i_pend && $urandom_range(1, 0) == 1) begin
        IReq = 1'b1; IAddr = 32'h200 + ($urandom_range(15, 0) << 2);
      end
      if (!d_pend && ($urandom_range(1, 0) == 1 || !IReq)) begin
        DReq = 1'b1; DWrite = $urandom_range(1, 0) == 1;
        DAddr = 32'h200 + ($urandom_range(15, 0) << 2);
        DWData = $urandom; DBHW = 2'($urandom_range(2, 0));
      end
      i_pend = IReq; d_pend = DReq;
      case ($urandom_range(7, 0))
        0: lt = 0;
        1: lt = 1;
        2: lt = 2;
        3: lt = 3;
        4: lt = 5;
        5: lt = 7;
        6: lt = 8;
        default: lt = 12;
      endcase
      service(lt, 1'b1, od, oe, ol);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
